// File: rtl/bist_pkg.sv
// ---------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the BIST session controller: default signature
// width, default fault-free signature and the session FSM state encoding.
// ---------------------------------------------------------------------------
package bist_pkg;

  localparam int          SIG_W  = 17;
  localparam logic [16:0] GOLDEN = 17'h17431;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } bist_state_e;

endpackage

// File: rtl/bist_cycle_cnt.sv
// ---------------------------------------------------------------------------
// bist_cycle_cnt
// Pattern-cycle counter for the BIST session. Clears synchronously,
// increments while enabled and saturates at the terminal value, so it can
// never wrap.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset (count -> 0)
//   i_clr  - synchronous clear (priority over enable)
//   i_en   - count enable
//   o_tc   - high while the count equals the terminal value
// ---------------------------------------------------------------------------
module bist_cycle_cnt #(
  parameter int CNT_W = 10,
  parameter int TERM  = 1021
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERM);

  logic [CNT_W-1:0] r_cnt;

  // Counter register: clear, saturating increment, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TC_VAL)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/bist_session_ctrl.sv
// ---------------------------------------------------------------------------
// bist_session_ctrl
// Sequences one BIST session: holds the BIST datapath in reset, runs a fixed
// number of pattern cycles, captures the MISR signature and compares it with
// the fault-free value. Dropping test mode mid-session aborts it.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - session request (acted on only when idle or done)
//   tm       - test-mode enable; 0 forces functional mode / aborts a session
//   sig_in   - MISR signature from the BIST block
//   bist_rst - active-high reset to the BIST LFSR/MISR
//   tm_out   - test mode to the BIST block, tm delayed by one cycle
//   busy     - session in progress
//   done     - result valid (held)
//   pass     - captured signature matched GOLDEN (valid with done)
//   abort    - last session terminated early (held)
//   sig_cap  - signature latched at end of session
// All outputs are registered.
// ---------------------------------------------------------------------------
module bist_session_ctrl
  import bist_pkg::*;
#(
  parameter int               SIG_W   = bist_pkg::SIG_W,
  parameter int               PAT_CNT = 1022,
  parameter logic [SIG_W-1:0] GOLDEN  = SIG_W'(bist_pkg::GOLDEN),
  parameter int               RST_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tm,
  input  logic [SIG_W-1:0] sig_in,
  output logic             bist_rst,
  output logic             tm_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             abort,
  output logic [SIG_W-1:0] sig_cap
);

  localparam int CNT_W = (PAT_CNT > 1) ? $clog2(PAT_CNT) : 1;
  localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

  bist_state_e      r_state;
  bist_state_e      w_state_nxt;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [RC_W-1:0]  w_rst_cnt_nxt;

  logic             r_bist_rst;
  logic             r_tm_out;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic             r_abort;
  logic [SIG_W-1:0] r_sig_cap;

  logic             w_bist_rst_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_pass_nxt;
  logic             w_abort_nxt;
  logic [SIG_W-1:0] w_sig_cap_nxt;

  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_cnt_tc;

  bist_cycle_cnt #(
    .CNT_W (CNT_W),
    .TERM  (PAT_CNT - 1)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_cnt_tc)
  );

  // State and output registers; reset holds the BIST datapath in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_rst_cnt  <= '0;
      r_bist_rst <= 1'b1;
      r_tm_out   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_abort    <= 1'b0;
      r_sig_cap  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_bist_rst <= w_bist_rst_nxt;
      r_tm_out   <= tm;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_abort    <= w_abort_nxt;
      r_sig_cap  <= w_sig_cap_nxt;
    end
  end

  // Next-state and next-output logic. Loss of test mode while busy wins
  // over every other transition, including the capture.
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_done_nxt    = r_done;
    w_pass_nxt    = r_pass;
    w_abort_nxt   = r_abort;
    w_sig_cap_nxt = r_sig_cap;
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start && tm) begin
          w_state_nxt   = ST_INIT;
          w_rst_cnt_nxt = '0;
          w_done_nxt    = 1'b0;
          w_pass_nxt    = 1'b0;
          w_abort_nxt   = 1'b0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_INIT: begin
        w_cnt_clr = 1'b1;
        if (!tm) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end else if (r_rst_cnt == RC_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RC_W'(1);
        end
      end
      ST_RUN: begin
        if (!tm) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end else if (w_cnt_tc) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (!tm) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
        end else begin
          w_state_nxt   = ST_DONE;
          w_sig_cap_nxt = sig_in;
          w_pass_nxt    = (sig_in == GOLDEN);
          w_done_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they line up with it.
    w_busy_nxt     = (w_state_nxt == ST_INIT) || (w_state_nxt == ST_RUN) ||
                     (w_state_nxt == ST_CAPTURE);
    w_bist_rst_nxt = (w_state_nxt == ST_INIT);
  end

  assign bist_rst = r_bist_rst;
  assign tm_out   = r_tm_out;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign abort    = r_abort;
  assign sig_cap  = r_sig_cap;

endmodule

// File: tb/tb_bist_session_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bist_session_ctrl
// Self-checking bench: a cycle-level behavioural model (session age counted
// in clock edges) is compared against every DUT output once per cycle, a
// table of directed sessions checks end results, then random traffic and a
// mid-session asynchronous reset.
// ---------------------------------------------------------------------------
module tb_bist_session_ctrl;

  localparam int          SW    = 17;
  localparam int          PAT   = 1022;
  localparam int          RCYC  = 2;
  localparam logic [16:0] GOLD  = 17'h17431;
  localparam int          BUSY_LEN = RCYC + PAT + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          tm;
  logic [SW-1:0] sig_in;
  logic          bist_rst, tm_out, busy, done, pass, abort;
  logic [SW-1:0] sig_cap;

  always #5 clk = ~clk;

  bist_session_ctrl #(
    .SIG_W   (SW),
    .PAT_CNT (PAT),
    .GOLDEN  (GOLD),
    .RST_CYC (RCYC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tm       (tm),
    .sig_in   (sig_in),
    .bist_rst (bist_rst),
    .tm_out   (tm_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .abort    (abort),
    .sig_cap  (sig_cap)
  );

  // Reference model: session age in clock edges since the start edge.
  bit            m_active;
  int            m_k;
  logic          m_done, m_pass, m_abort, m_bist_rst, m_tm_out;
  logic [SW-1:0] m_cap;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [SW-1:0] sig;
    int            drop_cyc;
    int            start_cyc;
    int            exp_busy;
    logic          exp_done;
    logic          exp_pass;
    logic          exp_abort;
    logic [SW-1:0] exp_cap;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active   = 1'b0;
    m_k        = 0;
    m_done     = 1'b0;
    m_pass     = 1'b0;
    m_abort    = 1'b0;
    m_bist_rst = 1'b1;
    m_tm_out   = 1'b0;
    m_cap      = '0;
  endtask

  task automatic model_edge();
    if (rst) begin
      m_tm_out = tm;
      if (m_active) begin
        if (!tm) begin
          m_active = 1'b0;
          m_abort  = 1'b1;
          m_done   = 1'b0;
          m_pass   = 1'b0;
        end else begin
          m_k++;
          if (m_k == BUSY_LEN) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_cap    = sig_in;
            m_pass   = (sig_in == GOLD);
          end
        end
      end else if (start && tm) begin
        m_active = 1'b1;
        m_k      = 0;
        m_done   = 1'b0;
        m_pass   = 1'b0;
        m_abort  = 1'b0;
      end
      m_bist_rst = m_active && (m_k < RCYC);
    end
  endtask

  task automatic check_all();
    chk("busy",     busy,     m_active);
    chk("done",     done,     m_done);
    chk("pass",     pass,     m_pass);
    chk("abort",    abort,    m_abort);
    chk("bist_rst", bist_rst, m_bist_rst);
    chk("tm_out",   tm_out,   m_tm_out);
    chk("sig_cap",  sig_cap,  m_cap);
  endtask

  // One clock: model steps on the edge, outputs compared at the falling edge.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int cur;
    //        sig       drop  start busy      done  pass  abort cap
    tbl[0] = '{17'h17431, -1,   -1, BUSY_LEN, 1'b1, 1'b1, 1'b0, 17'h17431};
    tbl[1] = '{17'h17430, -1,   -1, BUSY_LEN, 1'b1, 1'b0, 1'b0, 17'h17430};
    tbl[2] = '{17'h17431, RCYC + 500, -1, RCYC + 501, 1'b0, 1'b0, 1'b1, 17'h17430};
    tbl[3] = '{17'h17431, BUSY_LEN - 1, -1, BUSY_LEN, 1'b0, 1'b0, 1'b1, 17'h17430};
    tbl[4] = '{17'h17431, -1, RCYC + 10, BUSY_LEN, 1'b1, 1'b1, 1'b0, 17'h17431};
    tbl[5] = '{17'h00000, -1,   -1, BUSY_LEN, 1'b1, 1'b0, 1'b0, 17'h00000};

    rst = 1'b0; start = 1'b0; tm = 1'b0; sig_in = '0;
    model_reset();
    repeat (3) cyc();
    chk("rst_bist_rst", bist_rst, 1'b1);
    chk("rst_busy",     busy,     1'b0);
    chk("rst_done",     done,     1'b0);
    chk("rst_sig_cap",  sig_cap,  '0);

    rst = 1'b1; tm = 1'b1;
    cyc();
    chk("rel_bist_rst_drop", bist_rst, 1'b0);
    chk("rel_tm_out",        tm_out,   1'b1);

    for (int r = 0; r < 6; r++) begin
      sig_in = tbl[r].sig; start = 1'b1; tm = 1'b1;
      cyc();
      start = 1'b0;
      chk($sformatf("row%0d_entry_done", r),  done,     1'b0);
      chk($sformatf("row%0d_entry_pass", r),  pass,     1'b0);
      chk($sformatf("row%0d_entry_abort", r), abort,    1'b0);
      chk($sformatf("row%0d_entry_busy", r),  busy,     1'b1);
      chk($sformatf("row%0d_entry_brst", r),  bist_rst, 1'b1);
      cur = 0;
      while (busy === 1'b1 && cur < 1200) begin
        tm    = (cur != tbl[r].drop_cyc);
        start = (cur == tbl[r].start_cyc);
        cyc();
        cur++;
      end
      start = 1'b0; tm = 1'b1;
      chk($sformatf("row%0d_busy_len", r), cur,     tbl[r].exp_busy);
      chk($sformatf("row%0d_done", r),     done,    tbl[r].exp_done);
      chk($sformatf("row%0d_pass", r),     pass,    tbl[r].exp_pass);
      chk($sformatf("row%0d_abort", r),    abort,   tbl[r].exp_abort);
      chk($sformatf("row%0d_sig_cap", r),  sig_cap, tbl[r].exp_cap);
    end

    for (int i = 0; i < 8000; i++) begin
      start  = ($urandom_range(0, 7) == 0);
      tm     = ($urandom_range(0, 1499) != 0);
      sig_in = ($urandom_range(0, 1) == 0) ? GOLD : SW'($urandom);
      cyc();
    end

    // Make sure no session is left running, then reset mid-session.
    start = 1'b0; tm = 1'b0;
    cyc();
    tm = 1'b1; start = 1'b1; sig_in = GOLD;
    cyc();
    start = 1'b0;
    repeat (RCYC + 300) cyc();
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_bist_rst", bist_rst, 1'b1);
    chk("arst_tm_out",   tm_out,   1'b0);
    chk("arst_busy",     busy,     1'b0);
    chk("arst_done",     done,     1'b0);
    chk("arst_pass",     pass,     1'b0);
    chk("arst_abort",    abort,    1'b0);
    chk("arst_sig_cap",  sig_cap,  '0);
    model_reset();
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    chk("arst_rel_bist_rst", bist_rst, 1'b0);
    chk("arst_rel_busy",     busy,     1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
